// File: rtl/mvm_batch_sequencer_if.sv
// Host-stream and mesh-side signal bundle for mvm_batch_sequencer.
// master = environment (host streams + mesh array), slave = the sequencer.

interface mvm_batch_sequencer_if #(
  parameter int unsigned DW      = 8,
  parameter int unsigned ROWS    = 128,
  parameter int unsigned COLS    = 128,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned BATCH_W = 8
);
  localparam int unsigned AW = $clog2(ROWS) + $clog2(COLS);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_load_w;
  logic [BATCH_W-1:0]    cmd_batch;
  logic                  w_valid;
  logic                  w_ready;
  logic [DW-1:0]         w_data;
  logic                  x_valid;
  logic                  x_ready;
  logic [COLS*DW-1:0]    x_data;
  logic                  r_valid;
  logic                  r_ready;
  logic [ROWS*ACC_W-1:0] r_data;
  logic [1:0]            mesh_state;
  logic                  mesh_cfg_valid;
  logic [AW-1:0]         mesh_cfg_addr;
  logic [DW-1:0]         mesh_cfg_data;
  logic [COLS*DW-1:0]    mesh_x;
  logic [ROWS*ACC_W-1:0] mesh_result;
  logic                  busy;
  logic                  done;

  modport master (
    output cmd_valid, cmd_load_w, cmd_batch, w_valid, w_data, x_valid, x_data, r_ready,
           mesh_result,
    input  cmd_ready, w_ready, x_ready, r_valid, r_data, mesh_state, mesh_cfg_valid,
           mesh_cfg_addr, mesh_cfg_data, mesh_x, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_load_w, cmd_batch, w_valid, w_data, x_valid, x_data, r_ready,
           mesh_result,
    output cmd_ready, w_ready, x_ready, r_valid, r_data, mesh_state, mesh_cfg_valid,
           mesh_cfg_addr, mesh_cfg_data, mesh_x, busy, done
  );
endinterface

// File: rtl/mvm_batch_sequencer.sv
// Command-driven sequencer for the MAC mesh: optional weight reload, then a batch of x vectors.
// Define MVM_SEQ_PERF_EN to add the perf_busy / perf_stall cycle counters.

module mvm_batch_sequencer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned ROWS    = 128,
  parameter int unsigned COLS    = 128,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned LAT     = 256,
  parameter int unsigned BATCH_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mvm_batch_sequencer_if.slave bus
`ifdef MVM_SEQ_PERF_EN
  ,
  output logic [31:0]          perf_busy,
  output logic [31:0]          perf_stall
`endif
);

  localparam int unsigned AW = $clog2(ROWS) + $clog2(COLS);
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] LatInit = CW'(LAT - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StWaitX   = 3'd2;
  localparam logic [2:0] StCompute = 3'd3;
  localparam logic [2:0] StOutput  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [BATCH_W-1:0]    remaining_q, remaining_d;
  logic [AW-1:0]         waddr_q;
  logic [CW-1:0]         cnt_q;
  logic [COLS*DW-1:0]    mesh_x_q;
  logic [ROWS*ACC_W-1:0] r_data_q;
  logic                  cfg_valid_q;
  logic [AW-1:0]         cfg_addr_q;
  logic [DW-1:0]         cfg_data_q;
  logic                  done_s;

  logic cmd_hs, w_hs, x_hs, w_last, busy_s, capture;

  assign cmd_hs  = (state_q == StIdle) && bus.cmd_valid;
  assign w_hs    = (state_q == StLoad) && bus.w_valid;
  assign x_hs    = (state_q == StWaitX) && bus.x_valid;
  assign capture = (state_q == StCompute) && (cnt_q == '0);
  // Mesh dimensions are powers of two, so the last row-major address is all ones.
  assign w_last  = &waddr_q;
  assign busy_s  = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_s      = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          remaining_d = bus.cmd_batch;
          if (bus.cmd_load_w) begin
            state_d = StLoad;
          end else if (bus.cmd_batch == '0) begin
            done_s = 1'b1;
          end else begin
            state_d = StWaitX;
          end
        end
      end
      StLoad: begin
        if (bus.w_valid && w_last) begin
          if (remaining_q == '0) begin
            state_d = StIdle;
            done_s  = 1'b1;
          end else begin
            state_d = StWaitX;
          end
        end
      end
      StWaitX: begin
        if (bus.x_valid) state_d = StCompute;
      end
      StCompute: begin
        if (cnt_q == '0) state_d = StOutput;
      end
      StOutput: begin
        if (bus.r_ready) begin
          remaining_d = remaining_q - BATCH_W'(1);
          if (remaining_q == BATCH_W'(1)) begin
            state_d = StIdle;
            done_s  = 1'b1;
          end else begin
            state_d = StWaitX;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      waddr_q     <= '0;
      cnt_q       <= '0;
      mesh_x_q    <= '0;
      r_data_q    <= '0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cfg_valid_q <= w_hs;
      if (w_hs) begin
        cfg_addr_q <= waddr_q;
        cfg_data_q <= bus.w_data;
        waddr_q    <= waddr_q + AW'(1);
      end
      if (x_hs) begin
        mesh_x_q <= bus.x_data;
        cnt_q    <= LatInit;
      end else if ((state_q == StCompute) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (capture) r_data_q <= bus.mesh_result;
    end
  end

  // Ready/valid outputs decode registered state only.
  assign bus.cmd_ready      = (state_q == StIdle);
  assign bus.w_ready        = (state_q == StLoad);
  assign bus.x_ready        = (state_q == StWaitX);
  assign bus.r_valid        = (state_q == StOutput);
  assign bus.r_data         = r_data_q;
  assign bus.mesh_x         = mesh_x_q;
  assign bus.mesh_cfg_valid = cfg_valid_q;
  assign bus.mesh_cfg_addr  = cfg_addr_q;
  assign bus.mesh_cfg_data  = cfg_data_q;
  assign bus.busy           = busy_s;
  assign bus.done           = done_s && !rst;

  always_comb begin
    case (state_q)
      StIdle:              bus.mesh_state = 2'b00;
      StLoad:              bus.mesh_state = 2'b01;
      StWaitX, StCompute:  bus.mesh_state = 2'b10;
      StOutput:            bus.mesh_state = 2'b11;
      default:             bus.mesh_state = 2'b00;
    endcase
  end

`ifdef MVM_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;
  logic        stall_s;

  assign stall_s = ((state_q == StWaitX) && !bus.x_valid) ||
                   ((state_q == StOutput) && !bus.r_ready);

  always_ff @(posedge clk) begin
    if (rst || cmd_hs) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_s && !(&perf_busy_q)) perf_busy_q <= perf_busy_q + 32'd1;
      if (stall_s && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy  = perf_busy_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mvm_batch_sequencer.sv
// Scoreboard bench for mvm_batch_sequencer: drivers push expectations, a negedge monitor checks.
// The mesh is modelled as a fresh random result every cycle, so r_data pins down capture timing.

module tb_mvm_batch_sequencer;
  localparam int unsigned DW      = 8;
  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLS    = 4;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned LAT     = 6;
  localparam int unsigned BATCH_W = 8;
  localparam int unsigned NW      = ROWS * COLS;
  localparam int unsigned XW      = COLS * DW;
  localparam int unsigned RW      = ROWS * ACC_W;

  typedef struct { int cyc; int addr; int data; } cfg_t;
  typedef struct { int first; int src; logic [XW-1:0] x; } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  int   w_rdy_cyc = 0;
  int   x_rdy_cyc = 0;
  bit   r_seen = 1'b0;

  cfg_t          exp_cfg[$];
  res_t          exp_r[$];
  int            exp_done[$];
  logic [RW-1:0] hist[int];

  mvm_batch_sequencer_if #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .BATCH_W(BATCH_W)
  ) bus ();

`ifdef MVM_SEQ_PERF_EN
  logic [31:0] perf_busy, perf_stall;
`endif

  mvm_batch_sequencer #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .LAT(LAT), .BATCH_W(BATCH_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MVM_SEQ_PERF_EN
    ,
    .perf_busy(perf_busy),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_bits();
    logic [255:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
    return v;
  endfunction

  // Mesh model: every cycle presents a new random result, remembered by cycle index.
  always @(posedge clk) begin
    logic [RW-1:0] v;
    v = RW'(rand_bits());
    hist[cyc + 1] = v;
    bus.mesh_result <= v;
    cyc <= cyc + 1;
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string what);
    vectors++;
    errors++;
    $display("FAIL %s @cyc %0d: %s", nm, cyc, what);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rdy(input int k);
    case (k)
      0:       return bus.cmd_ready === 1'b1;
      1:       return bus.w_ready === 1'b1;
      2:       return bus.x_ready === 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int k, input string nm);
    int n = 0;
    while (!rdy(k) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) fail(nm, "got ready 0 for 400 cycles, want 1");
  endtask

  task automatic check_reset();
    check("rst_cmd_ready", 256'(bus.cmd_ready), 256'(1));
    check("rst_w_ready", 256'(bus.w_ready), 256'(0));
    check("rst_x_ready", 256'(bus.x_ready), 256'(0));
    check("rst_r_valid", 256'(bus.r_valid), 256'(0));
    check("rst_r_data", 256'(bus.r_data), 256'(0));
    check("rst_mesh_x", 256'(bus.mesh_x), 256'(0));
    check("rst_cfg_valid", 256'(bus.mesh_cfg_valid), 256'(0));
    check("rst_cfg_addr", 256'(bus.mesh_cfg_addr), 256'(0));
    check("rst_cfg_data", 256'(bus.mesh_cfg_data), 256'(0));
    check("rst_mesh_state", 256'(bus.mesh_state), 256'(0));
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_done", 256'(bus.done), 256'(0));
  endtask

  // Drives one whole command; xdel/rdel < 0 picks a random 0..3 stall per vector.
  task automatic run_cmd(input bit lw, input int batch, input bit seq_w, input int xdel,
                         input int rdel, input bit poke, output int t_acc, output int t_done);
    logic [DW-1:0] wd;
    logic [XW-1:0] xv;
    int n, xd, rd;
    t_done = -1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_load_w = lw;
    bus.cmd_batch  = BATCH_W'(batch);
    wait_for(0, "cmd_ready");
    t_acc = cyc;
    if (!lw && batch == 0) begin
      exp_done.push_back(cyc);
      t_done = cyc;
    end
    tick();
    bus.cmd_valid = 1'b0;
    if (lw || batch != 0) begin
      check("busy_after_accept", 256'(bus.busy), 256'(1));
      check("state_after_accept", 256'(bus.mesh_state), lw ? 256'(1) : 256'(2));
    end
    if (lw) begin
      for (int i = 0; i < int'(NW); i++) begin
        if (!seq_w && $urandom_range(3) == 0) begin
          bus.w_valid = 1'b0;
          repeat ($urandom_range(2, 1)) tick();
        end
        wd = seq_w ? DW'(i + 1) : DW'($urandom);
        bus.w_valid = 1'b1;
        bus.w_data  = wd;
        wait_for(1, "w_ready");
        exp_cfg.push_back('{cyc + 1, i, int'(wd)});
        if (i == int'(NW) - 1 && batch == 0) begin
          exp_done.push_back(cyc);
          t_done = cyc;
        end
        tick();
      end
      bus.w_valid = 1'b0;
    end
    for (int b = 0; b < batch; b++) begin
      xd = (xdel < 0) ? int'($urandom_range(3)) : xdel;
      rd = (rdel < 0) ? int'($urandom_range(3)) : rdel;
      repeat (xd) tick();
      xv = XW'(rand_bits());
      bus.x_valid = 1'b1;
      bus.x_data  = xv;
      wait_for(2, "x_ready");
      exp_r.push_back('{cyc + int'(LAT) + 1, cyc + int'(LAT), xv});
      tick();
      bus.x_valid = 1'b0;
      n = 0;
      while (bus.r_valid !== 1'b1 && n < 400) begin
        if (poke) begin
          bus.cmd_valid  = 1'b1;
          bus.cmd_load_w = 1'b1;
          bus.cmd_batch  = BATCH_W'(7);
          check("cmd_ready_while_busy", 256'(bus.cmd_ready), 256'(0));
        end
        tick();
        n++;
      end
      bus.cmd_valid = 1'b0;
      if (n >= 400) fail("r_valid_wait", "got r_valid 0 for 400 cycles, want 1");
      repeat (rd) tick();
      bus.r_ready = 1'b1;
      if (b == batch - 1) begin
        exp_done.push_back(cyc);
        t_done = cyc;
      end
      tick();
      bus.r_ready = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (bus.w_ready === 1'b1) w_rdy_cyc++;
    if (bus.x_ready === 1'b1) x_rdy_cyc++;

    if (exp_cfg.size() > 0 && exp_cfg[0].cyc == cyc) begin
      check("cfg_valid", 256'(bus.mesh_cfg_valid), 256'(1));
      check("cfg_addr", 256'(bus.mesh_cfg_addr), 256'(exp_cfg[0].addr));
      check("cfg_data", 256'(bus.mesh_cfg_data), 256'(exp_cfg[0].data));
      void'(exp_cfg.pop_front());
    end else if (bus.mesh_cfg_valid === 1'b1) begin
      fail("cfg_valid", "got 1, want 0");
    end

    if (bus.r_valid === 1'b1) begin
      if (exp_r.size() == 0 || cyc < exp_r[0].first) begin
        fail("r_valid", "got 1, want 0 (no result due)");
      end else begin
        if (!r_seen) begin
          check("r_latency", 256'(cyc), 256'(exp_r[0].first));
          r_seen = 1'b1;
        end
        check("r_data", 256'(bus.r_data), 256'(hist[exp_r[0].src]));
        if (bus.r_ready === 1'b1) begin
          check("mesh_x", 256'(bus.mesh_x), 256'(exp_r[0].x));
          void'(exp_r.pop_front());
          r_seen = 1'b0;
        end
      end
    end else if (exp_r.size() > 0 && cyc == exp_r[0].first) begin
      fail("r_latency", "got r_valid 0, want 1");
    end

    if (exp_done.size() > 0 && exp_done[0] == cyc) begin
      check("done", 256'(bus.done), 256'(1));
      void'(exp_done.pop_front());
    end else if (bus.done === 1'b1) begin
      fail("done", "got 1, want 0");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 ns, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ta, td, base;
    bus.cmd_valid  = 1'b0;
    bus.cmd_load_w = 1'b0;
    bus.cmd_batch  = '0;
    bus.w_valid    = 1'b0;
    bus.w_data     = '0;
    bus.x_valid    = 1'b0;
    bus.x_data     = '0;
    bus.r_ready    = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset();

    // Weights 1..16 back-to-back, one vector.
    run_cmd(1'b1, 1, 1'b1, 0, 0, 1'b0, ta, td);

    // Three vectors, long output stall, no weight traffic allowed.
    base = w_rdy_cyc;
    run_cmd(1'b0, 3, 1'b0, 1, 5, 1'b0, ta, td);
    check("no_w_ready_without_load", 256'(w_rdy_cyc - base), 256'(0));

    // Load only: x must never be requested.
    base = x_rdy_cyc;
    run_cmd(1'b1, 0, 1'b0, 0, 0, 1'b0, ta, td);
    tick();
    check("no_x_ready_batch0", 256'(x_rdy_cyc - base), 256'(0));

    // Commands offered while busy are ignored; batch count must be unaffected.
    run_cmd(1'b0, 2, 1'b0, -1, -1, 1'b1, ta, td);

    // Reset in the middle of a weight load.
    bus.cmd_valid  = 1'b1;
    bus.cmd_load_w = 1'b1;
    bus.cmd_batch  = BATCH_W'(2);
    wait_for(0, "cmd_ready");
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = DW'(8'hA0 + i);
      wait_for(1, "w_ready");
      exp_cfg.push_back('{cyc + 1, i, 8'hA0 + i});
      tick();
    end
    bus.w_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset();
    run_cmd(1'b1, 1, 1'b0, 0, 0, 1'b0, ta, td);

    // Empty command completes in its accept cycle.
    run_cmd(1'b0, 0, 1'b0, 0, 0, 1'b0, ta, td);
    check("zero_cmd_done_cycle", 256'(td), 256'(ta));

`ifdef MVM_SEQ_PERF_EN
    run_cmd(1'b0, 1, 1'b0, 4, 3, 1'b0, ta, td);
    tick();
    check("perf_stall", 256'(perf_stall), 256'(4 + 3));
    check("perf_busy", 256'(perf_busy), 256'((4 + 1) + int'(LAT) + (3 + 1)));
`endif

    for (int k = 0; k < 10; k++) begin
      run_cmd(1'($urandom_range(1)), int'($urandom_range(3)), 1'b0, -1, -1,
              1'($urandom_range(1)), ta, td);
    end

    repeat (3) tick();
    check("drain", 256'(exp_cfg.size() + exp_r.size() + exp_done.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mvm_batch_sequencer.md
# mvm_batch_sequencer

Parametrised control front-end for the 2-D MAC mesh, replacing the fixed start-driven FSM with a command-driven, handshaked sequencer. Accepts one command (optional weight reload plus a batch of N input vectors), streams weights into the mesh config port, feeds each x vector, waits the mesh latency, and returns each result vector over a ready/valid output. Sits between the host-side stream interfaces and the mesh array in the accelerator top.

## Interface
- DW, 8, signed element width of weights and x elements
- ROWS, 128, mesh rows (power of two, >=2)
- COLS, 128, mesh columns (power of two, >=2)
- ACC_W, 16, signed width of one result element
- LAT, 256, cycles from mesh_x/COMPUTE applied to mesh_result valid (>=1)
- BATCH_W, 8, width of the batch-count field
- AW (derived), $clog2(ROWS)+$clog2(COLS), weight address width

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_load_w  in  1  reload weights before the batch
- cmd_batch  in  BATCH_W  number of x vectors to process
- w_valid / w_ready  in / out  1  weight stream handshake
- w_data  in  DW  weight, row-major order
- x_valid / x_ready  in / out  1  x-vector handshake
- x_data  in  COLS*DW  one x vector
- r_valid / r_ready  out / in  1  result handshake
- r_data  out  ROWS*ACC_W  one result vector
- mesh_state  out  2  00 IDLE, 01 LOAD, 10 COMPUTE, 11 HOLD
- mesh_cfg_valid  out  1; mesh_cfg_addr  out  AW ({row,col}); mesh_cfg_data  out  DW
- mesh_x  out  COLS*DW; mesh_result  in  ROWS*ACC_W
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on command completion

## Operation
- States: IDLE, LOAD, WAIT_X, COMPUTE, OUTPUT.
- IDLE: cmd_ready=1. On cmd_valid: latch cmd_batch into remaining; go LOAD if cmd_load_w, else WAIT_X; if cmd_batch==0 and !cmd_load_w, pulse done and stay IDLE.
- LOAD: w_ready=1. Each w handshake drives mesh_cfg_valid=1, mesh_cfg_addr=address counter, mesh_cfg_data=w_data on the next cycle (registered). Counter starts at 0, increments per beat; beat ROWS*COLS-1 ends LOAD: go WAIT_X, or IDLE with done if remaining==0. Counter wraps to 0.
- WAIT_X: x_ready=1. On handshake register x_data into mesh_x (held until next capture), load cycle counter with LAT-1, go COMPUTE.
- COMPUTE: counter decrements each cycle; at 0 capture mesh_result into r_data, set r_valid, go OUTPUT.
- OUTPUT: r_valid and r_data held stable until r_ready. On handshake: remaining-1; if result 0, go IDLE and pulse done that cycle; else WAIT_X.
- mesh_state: IDLE->00, LOAD->01, WAIT_X/COMPUTE->10, OUTPUT->11.
- cmd_valid outside IDLE ignored (cmd_ready=0); w/x data outside their states not accepted.

## Timing
- Reset values: cmd_ready=1 after first post-reset cycle (state IDLE), w_ready=0, x_ready=0, r_valid=0, r_data=0, mesh_x=0, mesh_cfg_valid=0, mesh_cfg_addr=0, mesh_cfg_data=0, mesh_state=00, busy=0, done=0.
- Reset asserted mid-command: next cycle all of the above; partial weights not re-issued; counters cleared.
- Command accepted cycle T: LOAD/WAIT_X from T+1; busy=1 from T+1.
- Full load with w_valid held high: ROWS*COLS cycles; last mesh_cfg_valid one cycle after last beat.
- x handshake at cycle T: r_valid first high at T+LAT+1.
- r_valid and r_ready high same cycle as done: done and IDLE coincide; new cmd accepted no earlier than next cycle.
- All ready outputs are state-decoded only; no combinational path from any valid input to any ready output.

## Configuration
- MVM_SEQ_PERF_EN defined: adds outputs perf_busy (32) counting cycles with busy=1 and perf_stall (32) counting cycles in WAIT_X with x_valid=0 plus cycles in OUTPUT with r_ready=0; both cleared on command accept and on rst, saturate at all-ones.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- ROWS=COLS=4, LAT=6: reset mid-LOAD -> next cycle all outputs at reset values, state IDLE, cmd_ready=1.
- cmd_load_w=1, cmd_batch=1, 16 weights 1..16 streamed back-to-back -> mesh_cfg_addr 0..15 with data 1..16, one per cycle, then x accepted; r_valid exactly 7 cycles after x handshake.
- cmd_load_w=0, cmd_batch=3, r_ready held low 5 cycles per result -> r_data stable while stalled, 3 results, done once on third handshake, no weight beats accepted.
- cmd_load_w=1, cmd_batch=0 -> 16 weights loaded, done pulses, x_ready never asserted.
- cmd_valid asserted while busy -> cmd_ready=0, command ignored; remaining batch unchanged.
- MVM_SEQ_PERF_EN: batch=1 with x_valid delayed 4 cycles, r_ready delayed 3 -> perf_stall=7, perf_busy equals cycles from command accept+1 to done inclusive.
